sv32_walker: RTL and testbench
==============================

Name: sv32_walker

Overview:
- Sv32 page-table walker; the initiator side of the unified memory's LFM byte-fetch port.
- Takes a translation request, fetches up to two PTEs through the LFM_enable / LFM_resolved handshake, and checks permissions.
- Returns a physical address or a page fault.
- Holds a single-entry translation cache; one instance each serves the instruction and data paths.

Parameters:
- TIMEOUT, 64: max cycles to wait for LFM_resolved per PTE fetch before an access fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- req  in  1  translation request, sampled only in IDLE
- vaddr  in  32  virtual address, held stable while busy
- access_is_load / access_is_store / access_is_inst  in  1 each  access type, one-hot
- csr_satp  in  32  [31]=MODE, [21:0]=root PPN
- priv  in  2  current privilege (2'b11 = machine)
- sstatus_sum  in  1  SUM bit
- flush  in  1  sfence.vma: invalidate the cache entry
- LFM_resolved  in  1  responder has the four PTE bytes ready
- b1, b2, b3, b4  in  8 each  PTE bytes; b1 is at the lowest address
- LFM  out  32  PTE physical address
- LFM_enable  out  1  one-cycle fetch-start pulse
- busy  out  1  walk in progress (pipeline stall)
- done  out  1  one-cycle completion pulse
- paddr  out  32  translated address, valid with done
- instr_fault, load_fault, store_fault  out  1 each  page/access fault, valid with done
- faulting_va  out  32  vaddr of the faulting access, valid with done

Behaviour:
- Reset: all outputs 0; state IDLE; cache valid=0. Reset mid-walk aborts the walk immediately. A late LFM_resolved is ignored in IDLE.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE, on req:
  - Bare mode (satp[31]==0 or priv==11): RESP next cycle, paddr=vaddr, no fetch.
  - Cache hit (valid, tag==vaddr[31:12] for 4K or vaddr[31:22] for superpage): RESP next cycle, permissions rechecked.
  - Otherwise go to L1_REQ.
  - req in any other state is ignored.
- PTE word assembly: PTE = {b4,b3,b2,b1}, captured in the cycle LFM_resolved==1.
- L1_REQ:
  - LFM = {satp[19:0],12'b0} + {vaddr[31:22],2'b00}.
  - LFM_enable=1 for exactly this cycle, then go to L1_WAIT.
- L1_WAIT:
  - Hold LFM stable.
  - On LFM_resolved, evaluate PTE1.
  - If the timeout counter reaches TIMEOUT-1 first, raise a fault of the access type.
- L0_REQ / L0_WAIT: same handshake with LFM = {PTE1[29:10],12'b0} + {vaddr[21:12],2'b00}.
- PTE evaluation, faults first:
  - V==0, or R==0 && W==1: fault.
  - R|X==0 at L1: go to L0_REQ. R|X==0 at L0: fault.
  - L1 leaf with PTE[19:10]!=0 (misaligned superpage): fault.
  - A==0: fault. Store with D==0: fault. No hardware A/D update.
  - inst needs X; load needs R; store needs R and W.
  - U-mode (priv 00) needs U==1.
  - S-mode with U==1: inst always faults; load/store fault unless sstatus_sum.
- Address formation:
  - Superpage: paddr = {PTE[29:20], vaddr[21:0]}.
  - 4K page: paddr = {PTE[29:10], vaddr[11:0]}, with PPN[21:20] truncated.
- Fault outputs: only the flag matching the access type is set; faulting_va = vaddr; paddr = 0.
- RESP: done=1 for one cycle, then IDLE. busy=1 in every non-IDLE state, including RESP.
- Cache fill: only on a successful leaf. Stores tag, PPN, R/W/X/U/A/D and the superpage flag.
- Cache invalidation:
  - flush clears valid in any state; a walk in progress completes but does not fill.
  - A change of csr_satp also clears valid.
- Timeout counter: reset on each LFM_enable pulse.

Test Plan:
- Bare mode: satp=0x0000_0000, req, vaddr=0x0000_1234 -> done one cycle later, paddr=0x0000_1234, LFM_enable never asserted.
- Two-level walk: satp=0x8000_0010, priv=01, load, vaddr=0x0040_1234. Responder returns 0x0000_4401 at LFM=0x0001_0004, then 0x0000_80CF at LFM=0x0001_1004 -> paddr=0x0002_0234, no fault, exactly two LFM_enable pulses.
- Cache hit: repeat the same vaddr -> done one cycle after req, no LFM_enable. Then assert flush and repeat -> full walk again.
- Store with D=0: L0 PTE=0x0000_004F -> store_fault=1, faulting_va=0x0040_1234, paddr=0, cache not filled.
- U-bit / SUM: L0 PTE=0x0000_80DF, priv=01, load, sstatus_sum=0 -> load_fault. Same with sstatus_sum=1 -> paddr=0x0002_0234. inst access -> instr_fault regardless of SUM.
- Timeout and reset: LFM_resolved withheld -> fault exactly TIMEOUT cycles after the pulse. rst=0 during L0_WAIT -> IDLE, busy=0, a later LFM_resolved is ignored.

Source files
------------

// File: rtl/sv32_walker.sv
// rtl/sv32_walker.sv - Sv32 page-table walker with a single-entry translation cache
// Issues up to two PTE fetches over the LFM handshake and checks leaf permissions.
module sv32_walker #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] vaddr,
    input  logic        access_is_load,
    input  logic        access_is_store,
    input  logic        access_is_inst,
    input  logic [31:0] csr_satp,
    input  logic [1:0]  priv,
    input  logic        sstatus_sum,
    input  logic        flush,
    input  logic        LFM_resolved,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [7:0]  b4,
    output logic [31:0] LFM,
    output logic        LFM_enable,
    output logic        busy,
    output logic        done,
    output logic [31:0] paddr,
    output logic        instr_fault,
    output logic        load_fault,
    output logic        store_fault,
    output logic [31:0] faulting_va
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   lfm_q;
    logic          lfm_en_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   paddr_q;
    logic [31:0]   fva_q;
    logic          ifault_q;
    logic          lfault_q;
    logic          sfault_q;
    logic [31:0]   satp_q;
    logic          fill_ok_q;

    // Cache entry; perm packs {D, A, U, X, W, R}
    logic          c_valid_q;
    logic [19:0]   c_tag_q;
    logic [19:0]   c_ppn_q;
    logic [5:0]    c_perm_q;
    logic          c_super_q;

    logic [31:0] pte_w;
    logic        satp_chg;
    logic        bare;
    logic        hit;
    logic [31:0] hit_paddr;
    logic        hit_fault;
    logic        lvl1;
    logic        ev_fault;
    logic        ev_next;
    logic [5:0]  leaf_perm;
    logic [31:0] leaf_paddr;
    logic        fill_now;
    logic        unused_ok;

    function automatic logic perm_fault(
        input logic [5:0] p,
        input logic       ld,
        input logic       st,
        input logic       ins,
        input logic [1:0] pv,
        input logic       sum
    );
        logic f;
        f = !p[4]
            || (st && !p[5])
            || (ins && !p[2])
            || (ld && !p[0])
            || (st && !(p[0] && p[1]));
        if (pv == 2'b00) begin
            f = f || !p[3];
        end else begin
            f = f || (p[3] && (ins || !sum));
        end
        return f;
    endfunction

    assign pte_w     = {b4, b3, b2, b1};
    assign satp_chg  = (csr_satp != satp_q);
    assign bare      = !csr_satp[31] || (priv == 2'b11);
    assign unused_ok = ^{csr_satp[30:20], pte_w[31:30], pte_w[9:8], pte_w[5]};

    // A same-cycle flush or satp change must not be served from the stale entry
    assign hit = c_valid_q && !flush && !satp_chg &&
                 (c_super_q ? (c_tag_q[19:10] == vaddr[31:22]) : (c_tag_q == vaddr[31:12]));
    assign hit_paddr = c_super_q ? {c_ppn_q[19:10], vaddr[21:0]} : {c_ppn_q, vaddr[11:0]};
    assign hit_fault = perm_fault(c_perm_q, access_is_load, access_is_store, access_is_inst,
                                  priv, sstatus_sum);

    assign lvl1       = (state_q == L1_WAIT);
    assign leaf_perm  = {pte_w[7], pte_w[6], pte_w[4], pte_w[3], pte_w[2], pte_w[1]};
    assign leaf_paddr = lvl1 ? {pte_w[29:20], vaddr[21:0]} : {pte_w[29:10], vaddr[11:0]};
    assign fill_now   = fill_ok_q && !flush && !satp_chg;

    always_comb begin
        ev_fault = 1'b0;
        ev_next  = 1'b0;
        if (!pte_w[0] || (!pte_w[1] && pte_w[2])) begin
            ev_fault = 1'b1;
        end else if (!pte_w[1] && !pte_w[3]) begin
            if (lvl1) begin
                ev_next = 1'b1;
            end else begin
                ev_fault = 1'b1;
            end
        end else if (lvl1 && (pte_w[19:10] != 10'd0)) begin
            ev_fault = 1'b1;
        end else begin
            ev_fault = perm_fault(leaf_perm, access_is_load, access_is_store, access_is_inst,
                                  priv, sstatus_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lfm_q     <= '0;
            lfm_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            paddr_q   <= '0;
            fva_q     <= '0;
            ifault_q  <= 1'b0;
            lfault_q  <= 1'b0;
            sfault_q  <= 1'b0;
            satp_q    <= '0;
            fill_ok_q <= 1'b0;
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_ppn_q   <= '0;
            c_perm_q  <= '0;
            c_super_q <= 1'b0;
        end else begin
            satp_q <= csr_satp;
            if (flush || satp_chg) begin
                c_valid_q <= 1'b0;
                fill_ok_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        busy_q   <= 1'b1;
                        ifault_q <= 1'b0;
                        lfault_q <= 1'b0;
                        sfault_q <= 1'b0;
                        fva_q    <= '0;
                        if (bare) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            paddr_q <= vaddr;
                        end else if (hit) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            if (hit_fault) begin
                                paddr_q  <= '0;
                                fva_q    <= vaddr;
                                ifault_q <= access_is_inst;
                                lfault_q <= access_is_load;
                                sfault_q <= access_is_store;
                            end else begin
                                paddr_q <= hit_paddr;
                            end
                        end else begin
                            state_q   <= L1_REQ;
                            lfm_en_q  <= 1'b1;
                            cnt_q     <= '0;
                            lfm_q     <= {csr_satp[19:0], 12'b0} + {20'b0, vaddr[31:22], 2'b00};
                            fill_ok_q <= !flush && !satp_chg;
                        end
                    end
                end
                L1_REQ, L0_REQ: begin
                    lfm_en_q <= 1'b0;
                    cnt_q    <= cnt_q + 1'b1;
                    state_q  <= (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
                L1_WAIT, L0_WAIT: begin
                    if (LFM_resolved) begin
                        if (ev_fault) begin
                            state_q  <= RESP;
                            done_q   <= 1'b1;
                            paddr_q  <= '0;
                            fva_q    <= vaddr;
                            ifault_q <= access_is_inst;
                            lfault_q <= access_is_load;
                            sfault_q <= access_is_store;
                        end else if (ev_next) begin
                            state_q  <= L0_REQ;
                            lfm_en_q <= 1'b1;
                            cnt_q    <= '0;
                            lfm_q    <= {pte_w[29:10], 12'b0} + {20'b0, vaddr[21:12], 2'b00};
                        end else begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            paddr_q <= leaf_paddr;
                            if (fill_now) begin
                                c_valid_q <= 1'b1;
                                c_tag_q   <= vaddr[31:12];
                                c_ppn_q   <= pte_w[29:10];
                                c_perm_q  <= leaf_perm;
                                c_super_q <= lvl1;
                            end
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q  <= RESP;
                        done_q   <= 1'b1;
                        paddr_q  <= '0;
                        fva_q    <= vaddr;
                        ifault_q <= access_is_inst;
                        lfault_q <= access_is_load;
                        sfault_q <= access_is_store;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    ifault_q <= 1'b0;
                    lfault_q <= 1'b0;
                    sfault_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign LFM         = lfm_q;
    assign LFM_enable  = lfm_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign paddr       = paddr_q;
    assign instr_fault = ifault_q;
    assign load_fault  = lfault_q;
    assign store_fault = sfault_q;
    assign faulting_va = fva_q;

endmodule

// File: tb/tb_sv32_walker.sv
// tb/tb_sv32_walker.sv - directed bench for sv32_walker
module tb_sv32_walker;

    localparam int TO = 64;
    localparam logic [31:0] VA = 32'h0040_1234;
    localparam logic [2:0] LD = 3'b010;
    localparam logic [2:0] ST = 3'b001;
    localparam logic [2:0] IN = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] vaddr;
    logic        access_is_load, access_is_store, access_is_inst;
    logic [31:0] csr_satp;
    logic [1:0]  priv;
    logic        sstatus_sum;
    logic        flush;
    logic        LFM_resolved;
    logic [7:0]  b1, b2, b3, b4;
    logic [31:0] LFM;
    logic        LFM_enable;
    logic        busy;
    logic        done;
    logic [31:0] paddr;
    logic        instr_fault, load_fault, store_fault;
    logic [31:0] faulting_va;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int e0;
    int n;

    always #5 clk = ~clk;

    always @(posedge clk) if (LFM_enable) en_cnt++;

    sv32_walker #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .vaddr(vaddr),
        .access_is_load(access_is_load), .access_is_store(access_is_store),
        .access_is_inst(access_is_inst), .csr_satp(csr_satp), .priv(priv),
        .sstatus_sum(sstatus_sum), .flush(flush), .LFM_resolved(LFM_resolved),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .LFM(LFM), .LFM_enable(LFM_enable),
        .busy(busy), .done(done), .paddr(paddr), .instr_fault(instr_fault),
        .load_fault(load_fault), .store_fault(store_fault), .faulting_va(faulting_va)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] va, input logic [2:0] acc);
        vaddr = va;
        {access_is_inst, access_is_load, access_is_store} = acc;
        req = 1'b1;
        tick;
        req = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] pte);
        int k = 0;
        while (!LFM_enable && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_en"}, {31'b0, LFM_enable}, 32'd1);
        chk({tag, "_addr"}, LFM, exp_addr);
        tick;
        tick;
        {b4, b3, b2, b1} = pte;
        LFM_resolved = 1'b1;
        tick;
        LFM_resolved = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; vaddr = '0;
        {access_is_inst, access_is_load, access_is_store} = 3'b000;
        csr_satp = '0; priv = 2'b01; sstatus_sum = 1'b0; flush = 1'b0;
        LFM_resolved = 1'b0; {b4, b3, b2, b1} = '0;
        tick;
        tick;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_en", {31'b0, LFM_enable}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_lfm", LFM, 32'd0);
        chk("rst_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd0);
        rst = 1'b1;
        tick;

        // Bare mode
        e0 = en_cnt;
        start(32'h0000_1234, LD);
        chk("bare_done", {31'b0, done}, 32'd1);
        chk("bare_paddr", paddr, 32'h0000_1234);
        chk("bare_busy", {31'b0, busy}, 32'd1);
        tick;
        chk("bare_done_off", {31'b0, done}, 32'd0);
        chk("bare_busy_off", {31'b0, busy}, 32'd0);
        chk("bare_no_fetch", en_cnt - e0, 32'd0);

        // Two-level walk
        csr_satp = 32'h8000_0010;
        tick;
        e0 = en_cnt;
        start(VA, LD);
        serve("walk_l1", 32'h0001_0004, 32'h0000_4401);
        serve("walk_l0", 32'h0001_1004, 32'h0000_80CF);
        wait_done("walk");
        chk("walk_paddr", paddr, 32'h0002_0234);
        chk("walk_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd0);
        chk("walk_pulses", en_cnt - e0, 32'd2);
        tick;

        // Cache hit, then flush forces a new walk
        e0 = en_cnt;
        start(VA, LD);
        chk("hit_done", {31'b0, done}, 32'd1);
        chk("hit_paddr", paddr, 32'h0002_0234);
        chk("hit_no_fetch", en_cnt - e0, 32'd0);
        tick;
        do_flush;
        e0 = en_cnt;
        start(VA, LD);
        serve("fl_l1", 32'h0001_0004, 32'h0000_4401);
        serve("fl_l0", 32'h0001_1004, 32'h0000_80CF);
        wait_done("fl");
        chk("fl_paddr", paddr, 32'h0002_0234);
        chk("fl_pulses", en_cnt - e0, 32'd2);
        tick;

        // Store to a page with D=0
        do_flush;
        start(VA, ST);
        serve("st_l1", 32'h0001_0004, 32'h0000_4401);
        serve("st_l0", 32'h0001_1004, 32'h0000_004F);
        wait_done("st");
        chk("st_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd1);
        chk("st_fva", faulting_va, VA);
        chk("st_paddr", paddr, 32'd0);
        tick;
        start(VA, ST);
        chk("st_nofill_done", {31'b0, done}, 32'd0);
        serve("st2_l1", 32'h0001_0004, 32'h0000_4401);
        serve("st2_l0", 32'h0001_1004, 32'h0000_004F);
        wait_done("st2");
        chk("st2_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd1);
        tick;

        // U page from S-mode with and without SUM
        do_flush;
        sstatus_sum = 1'b0;
        start(VA, LD);
        serve("u0_l1", 32'h0001_0004, 32'h0000_4401);
        serve("u0_l0", 32'h0001_1004, 32'h0000_80DF);
        wait_done("u0");
        chk("u0_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd2);
        chk("u0_paddr", paddr, 32'd0);
        tick;
        sstatus_sum = 1'b1;
        start(VA, LD);
        serve("u1_l1", 32'h0001_0004, 32'h0000_4401);
        serve("u1_l0", 32'h0001_1004, 32'h0000_80DF);
        wait_done("u1");
        chk("u1_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd0);
        chk("u1_paddr", paddr, 32'h0002_0234);
        tick;
        e0 = en_cnt;
        start(VA, IN);
        chk("ui_done", {31'b0, done}, 32'd1);
        chk("ui_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd4);
        chk("ui_paddr", paddr, 32'd0);
        chk("ui_no_fetch", en_cnt - e0, 32'd0);
        tick;

        // Superpage leaf and misaligned superpage
        do_flush;
        e0 = en_cnt;
        start(VA, LD);
        serve("sp_l1", 32'h0001_0004, 32'h0200_00CF);
        wait_done("sp");
        chk("sp_paddr", paddr, 32'h0800_1234);
        chk("sp_pulses", en_cnt - e0, 32'd1);
        tick;
        do_flush;
        start(VA, LD);
        serve("mis_l1", 32'h0001_0004, 32'h0200_04CF);
        wait_done("mis");
        chk("mis_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd2);
        tick;

        // Timeout: fault TIMEOUT cycles after the fetch pulse
        do_flush;
        start(VA, LD);
        chk("to_en", {31'b0, LFM_enable}, 32'd1);
        n = 0;
        while (!done && n < 200) begin
            tick;
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_faults", {29'b0, instr_fault, load_fault, store_fault}, 32'd2);
        chk("to_paddr", paddr, 32'd0);
        tick;

        // Reset during L0_WAIT
        do_flush;
        start(VA, LD);
        serve("rs_l1", 32'h0001_0004, 32'h0000_4401);
        chk("rs_l0_en", {31'b0, LFM_enable}, 32'd1);
        tick;
        chk("rs_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("rs_busy", {31'b0, busy}, 32'd0);
        chk("rs_en", {31'b0, LFM_enable}, 32'd0);
        chk("rs_done", {31'b0, done}, 32'd0);
        {b4, b3, b2, b1} = 32'h0000_80CF;
        LFM_resolved = 1'b1;
        tick;
        LFM_resolved = 1'b0;
        chk("rs_late_done", {31'b0, done}, 32'd0);
        chk("rs_late_busy", {31'b0, busy}, 32'd0);
        tick;
        chk("rs_late_done2", {31'b0, done}, 32'd0);
        chk("rs_late_paddr", paddr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
